ps2_tx: RTL and testbench
=========================

Name: ps2_tx

Overview:
Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA host to the keyboard or mouse. Uses open-collector line control: the block only ever drives a line low or releases it, so it shares ps2_clk/ps2_data with the existing PS/2 receiver through top-level tristate buffers. Flow: inhibit request, device-clocked 11-bit frame, device acknowledge.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the host holds ps2_clk low before the start bit (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clk cycles from clock release to device ACK (20 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  8  command byte to send
tx_valid  input  1  request; byte accepted when tx_valid && tx_ready
tx_ready  output  1  high only in IDLE
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse: frame sent and ACK received
error  output  1  one-cycle pulse: NACK or timeout
ps2_clk_in  input  1  raw PS/2 clock line (asynchronous)
ps2_data_in  input  1  raw PS/2 data line (asynchronous)
ps2_clk_drive_low  output  1  1 = pull clock line low, 0 = release
ps2_data_drive_low  output  1  1 = pull data line low, 0 = release

Behaviour:
- Reset (async, immediate): both drive_low = 0 (lines released), done = error = 0, busy = 0, tx_ready = 1, state IDLE, all counters 0.
- Input conditioning: 3-flop synchronizer per line. Clock line has a 2-sample agreement filter (level changes only when two consecutive synced samples agree). Falling edge = previous filtered 1, current filtered 0.
- IDLE: on accept, latch tx_data. Compute parity = ~^tx_data (odd parity). Go to INHIBIT. tx_valid while busy is ignored.
- INHIBIT: clk_drive_low = 1 for INHIBIT_CYCLES cycles. data_drive_low = 1 during the final cycle. Then go to REQ.
- REQ: clk_drive_low = 0, data_drive_low = 1 (start bit). Timeout counter starts from 0. Bit counter n = 0.
- On each filtered falling edge in REQ/SEND, increment n, then act as follows:
  - n = 1..8: data_drive_low = ~tx_data[n-1] (LSB first)
  - n = 9: data_drive_low = ~parity
  - n = 10: data_drive_low = 0 (stop bit); go to ACK
- ACK: on the 11th falling edge, sample filtered data. 0 means ACK: go to WAIT_REL. 1 means NACK: release both lines, pulse error, go to IDLE.
- WAIT_REL: when filtered clock and data are both 1, pulse done and go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in REQ/SEND/ACK/WAIT_REL: release both lines, pulse error, go to IDLE. This takes priority over a same-cycle edge.
- done and error never assert in the same cycle. Each pulse lasts exactly one cycle and is coincident with tx_ready rising.
- Counter widths come from $clog2 of the parameters. Bit counter is 4 bits.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: NACK or timeout does not return to IDLE. The block re-enters INHIBIT with the latched byte, up to 2 retries. error pulses only after the 3rd failure. A retry count output is not added.
- Undefined: a single attempt; first failure pulses error.

Decomposition:
- Package ps2_pkg holds:
  - state enum: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL
  - constants PS2_FRAME_BITS = 11, PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_RESET = 8'hFF, PS2_ACK_BYTE = 8'hFA
- Sub-module ps2_line_sync: synchronizer, filter and falling-edge detect for one line. Shared with the PS/2 receiver.

Test Plan (INHIBIT_CYCLES = 10, TIMEOUT_CYCLES = 3000; bench device model clocks at 1/40 clk and samples data on rising edges):
- Send 0xED with device ACK -> clock low exactly 10 cycles; device samples 0,1,0,1,1,0,1,1,1,1 (start, LSB-first data, parity 1) then released stop; done pulses once; no error.
- Send 0xFF -> sampled parity 0; send 0x00 -> sampled parity 1; both done.
- Device drives data high at the ACK edge -> error pulse; done stays 0; both drive_low = 0 the next cycle; tx_ready = 1.
- Device never clocks after REQ -> error exactly 3000 cycles after clock release; lines released.
- tx_valid pulsed with 0x12 while busy -> ignored; only the first byte appears on the wire.
- rst_n asserted mid-frame (after bit 4) -> both drive_low = 0 without waiting for a clk edge; after release, sending 0xF4 completes normally.
- With PS2_TX_RETRY_EN defined and two NACKs then an ACK -> three inhibit phases seen, single done, no error.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants: transmitter state encoding, frame size, common command bytes.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_REL
  } ps2_state_e;

  localparam int         PS2_FRAME_BITS   = 11;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  // Odd parity bit: makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 3-flop synchronizer, optional 2-sample agreement filter, falling-edge strobe.
`timescale 1ns/1ps
module ps2_line_sync #(
  parameter bit FILTER = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic [2:0] sync;
  logic       sample_q;
  logic       level_q;

  // Idle PS/2 lines float high, so resetting to 1 avoids a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= 3'b111;
      sample_q <= 1'b1;
      level    <= 1'b1;
      level_q  <= 1'b1;
    end else begin
      sync     <= {sync[1:0], line_in};
      sample_q <= sync[2];
      level_q  <= level;
      if (!FILTER || (sync[2] == sample_q))
        level <= sync[2];
    end
  end

  assign fall = level_q & ~level;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 command transmitter with open-collector line control.
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to twice before pulsing error.
`timescale 1ns/1ps
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int INH_W = ($clog2(INHIBIT_CYCLES) > 0) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic             DATA_AT_ENTRY = (INHIBIT_CYCLES == 1);

  ps2_state_e       state, state_n;
  logic [7:0]       data_q, data_n;
  logic             par_q, par_n;
  logic [INH_W-1:0] inh_cnt, inh_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic [3:0]       bit_cnt, bit_n, bit_inc;
  logic             clk_drv_n, data_drv_n;
  logic             done_n, err_n, fail;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_cnt, retry_n;
`endif

  logic clk_level, clk_fall, data_level, data_fall_unused;

  ps2_line_sync #(.FILTER(1'b1)) u_clk_sync (
    .clk(clk), .rst_n(rst_n), .line_in(ps2_clk_in), .level(clk_level), .fall(clk_fall)
  );

  ps2_line_sync #(.FILTER(1'b0)) u_data_sync (
    .clk(clk), .rst_n(rst_n), .line_in(ps2_data_in), .level(data_level), .fall(data_fall_unused)
  );

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;
  assign bit_inc  = bit_cnt + 4'd1;

  always_comb begin
    state_n    = state;
    data_n     = data_q;
    par_n      = par_q;
    inh_n      = inh_cnt;
    tmo_n      = tmo_cnt;
    bit_n      = bit_cnt;
    clk_drv_n  = ps2_clk_drive_low;
    data_drv_n = ps2_data_drive_low;
    done_n     = 1'b0;
    err_n      = 1'b0;
    fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n    = retry_cnt;
`endif
    case (state)
      IDLE: begin
        if (tx_valid) begin
          data_n     = tx_data;
          par_n      = odd_parity(tx_data);
          inh_n      = INH_LOAD;
          clk_drv_n  = 1'b1;
          data_drv_n = DATA_AT_ENTRY;
          state_n    = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_n    = 2'd0;
`endif
        end
      end
      INHIBIT: begin
        if (inh_cnt == '0) begin
          clk_drv_n  = 1'b0;
          data_drv_n = 1'b1;
          tmo_n      = '0;
          bit_n      = 4'd0;
          state_n    = REQ;
        end else begin
          inh_n = inh_cnt - 1'b1;
          if (inh_cnt == INH_W'(1))
            data_drv_n = 1'b1;
        end
      end
      REQ, SEND: begin
        if (tmo_cnt == TMO_LAST) begin
          fail = 1'b1;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
          if (clk_fall) begin
            bit_n = bit_inc;
            if (bit_inc <= 4'd8) begin
              data_drv_n = ~data_q[bit_cnt[2:0]];
              state_n    = SEND;
            end else if (bit_inc == 4'd9) begin
              data_drv_n = ~par_q;
            end else begin
              data_drv_n = 1'b0;
              state_n    = ACK;
            end
          end
        end
      end
      ACK: begin
        if (tmo_cnt == TMO_LAST) begin
          fail = 1'b1;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
          if (clk_fall) begin
            if (!data_level) state_n = WAIT_REL;
            else             fail    = 1'b1;
          end
        end
      end
      WAIT_REL: begin
        if (tmo_cnt == TMO_LAST) begin
          fail = 1'b1;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
          if (clk_level && data_level) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt != 2'd2) begin
        retry_n    = retry_cnt + 2'd1;
        inh_n      = INH_LOAD;
        clk_drv_n  = 1'b1;
        data_drv_n = DATA_AT_ENTRY;
        state_n    = INHIBIT;
      end else begin
        clk_drv_n  = 1'b0;
        data_drv_n = 1'b0;
        err_n      = 1'b1;
        state_n    = IDLE;
      end
`else
      clk_drv_n  = 1'b0;
      data_drv_n = 1'b0;
      err_n      = 1'b1;
      state_n    = IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      data_q             <= 8'h00;
      par_q              <= 1'b0;
      inh_cnt            <= '0;
      tmo_cnt            <= '0;
      bit_cnt            <= 4'd0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt          <= 2'd0;
`endif
    end else begin
      state              <= state_n;
      data_q             <= data_n;
      par_q              <= par_n;
      inh_cnt            <= inh_n;
      tmo_cnt            <= tmo_n;
      bit_cnt            <= bit_n;
      ps2_clk_drive_low  <= clk_drv_n;
      ps2_data_drive_low <= data_drv_n;
      done               <= done_n;
      error              <= err_n;
`ifdef PS2_TX_RETRY_EN
      retry_cnt          <= retry_n;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: behavioural PS/2 device on wire-AND lines, scoreboard of expected outcomes and frames.
`timescale 1ns/1ps
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH = 10;
  localparam int TMO = 3000;
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_ABORT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         mode;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          inh_run = 0, inh_dat = 0, inh_count = 0;
  logic        prev_cdl = 1'b0;
  logic [10:0] dev_frame = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wire order as sampled by the device: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Monitor: inhibit phase shape, clock-release time, and scoreboard pops on done/error.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      inh_run  = 0;
      inh_dat  = 0;
      prev_cdl = 1'b0;
    end else begin
      if (ps2_clk_drive_low) begin
        inh_run++;
        if (ps2_data_drive_low) inh_dat++;
      end else if (inh_run != 0) begin
        chk("inhibit_len", inh_run, INH);
        chk("inhibit_data_cycles", inh_dat, 1);
        inh_count++;
        inh_run = 0;
        inh_dat = 0;
      end
      if (prev_cdl && !ps2_clk_drive_low) rel_cyc = cyc;
      prev_cdl = ps2_clk_drive_low;
      if (done || error) begin
        chk("done_error_exclusive", done & error, 0);
        chk("ready_with_pulse", tx_ready, 1);
        chk("pulse_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("outcome_done", done, e.mode == M_ACK);
          if (e.mode == M_SILENT) chk("timeout_latency", cyc - rel_cyc, TMO);
          else                    chk("frame", dev_frame, model_frame(e.b));
          if (error) chk("lines_released", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        end
      end
    end
  end

  task automatic device_run(input int mode);
    int          n;
    logic [10:0] frame;
    frame = '0;
    n = 0;
    while (!ps2_clk_drive_low && n < 200) begin @(negedge clk); n++; end
    chk("inhibit_started", ps2_clk_drive_low, 1);
    n = 0;
    while (ps2_clk_drive_low && n < 200) begin @(negedge clk); n++; end
    chk("clock_released", ps2_clk_drive_low, 0);
    if (mode == M_SILENT) return;
    for (int i = 0; i < 10; i++) begin
      repeat (20) @(negedge clk);
      frame[i] = ps2_data_in;
      if (mode == M_ABORT && i == 5) begin
        dev_frame = frame;
        return;
      end
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (20) @(negedge clk);
    frame[10] = ps2_data_in;
    dev_frame = frame;
    if (mode == M_ACK) dev_data = 1'b0;
    repeat (8) @(negedge clk);
    dev_clk = 1'b0;
    repeat ((mode == M_NACK) ? 8 : 20) @(negedge clk);
    dev_clk = 1'b1;
    if (mode == M_ACK) begin
      repeat (5) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int mode);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    if (mode != M_ABORT) sb.push_back('{b: b, mode: mode});
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!tx_ready && n < limit) begin @(negedge clk); n++; end
    chk("returned_idle", tx_ready, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         base;
    repeat (3) @(negedge clk);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {done, error}, 0);
    chk("reset_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(PS2_CMD_SET_LEDS, M_ACK); device_run(M_ACK); wait_idle(200);
    send(PS2_CMD_RESET, M_ACK);    device_run(M_ACK); wait_idle(200);
    send(8'h00, M_ACK);            device_run(M_ACK); wait_idle(200);
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      send(b, M_ACK); device_run(M_ACK); wait_idle(200);
    end

`ifdef PS2_TX_RETRY_EN
    base = inh_count;
    b = 8'($urandom_range(0, 255));
    send(b, M_ACK);
    device_run(M_NACK);
    device_run(M_NACK);
    device_run(M_ACK);
    wait_idle(400);
    chk("retry_inhibit_phases", inh_count - base, 3);
`else
    base = inh_count;
    b = 8'($urandom_range(0, 255));
    send(b, M_NACK); device_run(M_NACK); wait_idle(200);
    chk("nack_single_attempt", inh_count - base, 1);
    send(8'($urandom_range(0, 255)), M_SILENT); device_run(M_SILENT); wait_idle(TMO + 500);
`endif

    send(8'hA5, M_ACK);
    fork
      device_run(M_ACK);
      begin
        repeat (60) @(negedge clk);
        chk("busy_during_frame", busy, 1);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_idle(200);
    repeat (40) @(negedge clk);
    chk("ignored_byte_not_sent", tx_ready, 1);

    b = 8'($urandom_range(0, 255)) & 8'hEF;
    send(b, M_ABORT);
    device_run(M_ABORT);
    chk("pre_reset_data_low", ps2_data_drive_low, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    chk("async_reset_ready", tx_ready, 1);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(8'hF4, M_ACK); device_run(M_ACK); wait_idle(200);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
